// File: rtl/instr_dispatch.sv
// instr_dispatch
//   Front end of the microcode sequencer. It fetches one 32-bit LEGv8 word
//   at a time and latches it into the instruction register. The opcode field
//   of that word goes to the sequencer, together with a one-cycle sos pulse.
//   The block then waits for the sequencer's eos and advances the PC, either
//   sequentially or to a branch target supplied by the datapath. A halt
//   opcode (all ones) stops dispatch. A segment that never returns eos trips
//   a watchdog. Fetch and execute never overlap.
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   run                   level enable; 0 lets the current instruction finish
//   imem_req/addr/ack/rdata  instruction fetch handshake (addr = pc)
//   instr, opcode         instruction register and its opcode field
//   sos / eos             segment start pulse out / segment end in
//   pc_load, pc_target    datapath branch request, sampled during EXEC
//   pc                    address of the current instruction
//   halted, fault         sticky terminal status, cleared only by rst
module instr_dispatch #(
  parameter int              ADDR_W     = 32,
  parameter int              OPCODE_W   = 6,
  parameter int              OPCODE_LSB = 26,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT    = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic                sos,
  input  logic                eos,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_target,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic                fault
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DISPATCH, S_EXEC, S_HALT, S_FAULT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d, tgt_q, tgt_d;
  logic [31:0]           instr_q, instr_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic                  sos_q, sos_d, req_q, req_d;
  logic                  halted_q, halted_d, fault_q, fault_d;
  logic                  pend_q, pend_d;
  logic [WD_W-1:0]       wd_q, wd_d, wd_inc;

  assign wd_inc = wd_q + WD_W'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    instr_d  = instr_q;
    opcode_d = opcode_q;
    sos_d    = 1'b0;
    req_d    = req_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    pend_d   = pend_q;
    wd_d     = wd_q;
    case (state_q)
      S_IDLE: begin
        req_d = 1'b0;
        if (run) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end
      end
      S_FETCH: begin
        req_d = 1'b1;
        if (imem_ack) begin
          instr_d  = imem_rdata;
          opcode_d = imem_rdata[OPCODE_LSB +: OPCODE_W];
          req_d    = 1'b0;
          state_d  = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (&opcode_q) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          // sos is registered, so it is visible during the first EXEC cycle
          sos_d   = 1'b1;
          wd_d    = '0;
          pend_d  = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wd_d = wd_inc;
        if (pc_load) begin
          pend_d = 1'b1;
          tgt_d  = pc_target;
        end
        // wd_q==0 marks the first EXEC cycle; eos there is stale from the
        // sequencer's control latency and must not end the segment
        if (eos && (wd_q != '0)) begin
          if (pc_load)     pc_d = pc_target;
          else if (pend_q) pc_d = tgt_q;
          else             pc_d = pc_q + ADDR_W'(4);
          if (run) begin
            state_d = S_FETCH;
            req_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wd_inc == WD_W'(TIMEOUT)) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end
      end
      S_HALT, S_FAULT: req_d = 1'b0;
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      instr_q  <= '0;
      opcode_q <= '0;
      sos_q    <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      pend_q   <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      instr_q  <= instr_d;
      opcode_q <= opcode_d;
      sos_q    <= sos_d;
      req_q    <= req_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      pend_q   <= pend_d;
      wd_q     <= wd_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign opcode    = opcode_q;
  assign sos       = sos_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch: fetch/dispatch/exec flow, branch
// selection, halt, watchdog fault, reset during fetch and PC wraparound.
module tb_instr_dispatch;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack, eos, pc_load;
  logic [31:0] imem_rdata, pc_target;
  logic        imem_req, sos, halted, fault;
  logic [31:0] imem_addr, instr, pc;
  logic [5:0]  opcode;

  instr_dispatch #(.ADDR_W(32), .OPCODE_W(6), .OPCODE_LSB(26),
                   .RESET_PC(32'h0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode), .sos(sos),
    .eos(eos), .pc_load(pc_load), .pc_target(pc_target), .pc(pc),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [31:0] exp_pc;
  logic [5:0]  op_q[$];
  logic [31:0] pc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mkw(input logic [5:0] op);
    return {op, 26'h0ABCDE};
  endfunction

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    eos = 1'b0; pc_load = 1'b0; pc_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    op_q.delete();
    pc_q.delete();
  endtask

  // Wait for a request, check its address, ack after dly cycles.
  // Returns at the negedge where the DUT sits in DISPATCH.
  task automatic fetch(input logic [31:0] w, input int dly);
    int n = 0;
    while (imem_req !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'h1);
    chk("imem_addr", imem_addr, exp_pc);
    op_q.push_back(w[31:26]);
    repeat (dly) @(negedge clk);
    chk("req_held", 32'(imem_req), 32'h1);
    imem_ack = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = '0;
    chk("instr", instr, w);
    chk("req_drop", 32'(imem_req), 32'h0);
  endtask

  // Run one EXEC phase; l1/l2 are pc_load cycles (0 = none), l2 after l1.
  task automatic exec(input int eos_at, input int l1, input logic [31:0] t1,
                      input int l2, input logic [31:0] t2,
                      input bit early_eos, input bit run_v);
    logic [31:0] e;
    logic [5:0]  eop;
    e = exp_pc + 32'd4;
    if (l1 != 0 && l1 <= eos_at) e = t1;
    if (l2 != 0 && l2 <= eos_at) e = t2;
    pc_q.push_back(e);
    eop = op_q.pop_front();
    chk("dispatch_opcode", 32'(opcode), 32'(eop));
    chk("sos_in_dispatch", 32'(sos), 32'h0);
    run = run_v;
    for (int c = 1; c <= eos_at; c++) begin
      @(negedge clk);
      if (c == 1) chk("sos_pulse", 32'(sos), 32'h1);
      if (c == 2) begin
        chk("sos_one_cycle", 32'(sos), 32'h0);
        chk("pc_hold", pc, exp_pc);
      end
      eos       = (c == eos_at) || (early_eos && c == 1);
      pc_load   = (c == l1) || (c == l2);
      pc_target = (c == l2) ? t2 : t1;
    end
    @(negedge clk);
    eos = 1'b0; pc_load = 1'b0;
    exp_pc = pc_q.pop_front();
    chk("pc_update", pc, exp_pc);
    chk("sos_after", 32'(sos), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    logic [5:0] eop;
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_sos", 32'(sos), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);

    // basic sequential flow, early eos ignored, branch variants
    run = 1'b1;
    fetch(mkw(6'h05), 1); exec(3, 0, 0, 0, 0, 0, 1);                       // pc 4
    fetch(mkw(6'h06), 1); exec(3, 0, 0, 0, 0, 1, 1);                       // pc 8
    fetch(mkw(6'h07), 2); exec(3, 1, 32'h40, 0, 0, 0, 1);                  // pc 40
    fetch(mkw(6'h08), 0); exec(3, 1, 32'h40, 2, 32'h80, 0, 1);             // pc 80
    fetch(mkw(6'h09), 1); exec(3, 1, 32'h40, 3, 32'h10, 0, 1);             // pc 10
    // wraparound, then run dropped during EXEC
    fetch(mkw(6'h0A), 1); exec(2, 1, 32'hFFFF_FFFC, 0, 0, 0, 1);
    fetch(mkw(6'h0B), 1); exec(4, 0, 0, 0, 0, 0, 0);                       // pc 0
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req !== 1'b0) bad++;
    end
    chk("idle_no_req", 32'(bad), 32'h0);

    // watchdog: eos never arrives
    run = 1'b1;
    fetch(mkw(6'h0C), 1);
    eop = op_q.pop_front();
    chk("wd_opcode", 32'(opcode), 32'(eop));
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (c == 1)  chk("wd_sos", 32'(sos), 32'h1);
      if (c == TO) chk("fault_not_early", 32'(fault), 32'h0);
    end
    @(negedge clk);
    chk("fault_set", 32'(fault), 32'h1);
    chk("fault_pc", pc, exp_pc);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || sos !== 1'b0 || fault !== 1'b1) bad++;
    end
    chk("fault_terminal", 32'(bad), 32'h0);

    // halt opcode
    do_reset();
    run = 1'b1;
    fetch(mkw(6'h3F), 1);
    eop = op_q.pop_front();
    chk("halt_opcode", 32'(opcode), 32'(eop));
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || sos !== 1'b0) bad++;
    end
    chk("halt_quiet", 32'(bad), 32'h0);
    chk("halted", 32'(halted), 32'h1);
    chk("halt_pc", pc, 32'h0);

    // reset during a slow fetch; stale ack afterwards
    do_reset();
    run = 1'b1;
    fetch(mkw(6'h05), 0); exec(2, 0, 0, 0, 0, 0, 1);                       // pc 4
    @(negedge clk);
    chk("slow_req", 32'(imem_req), 32'h1);
    chk("slow_addr", imem_addr, 32'h4);
    repeat (2) @(negedge clk);
    rst = 1'b1; run = 1'b0;
    #1;
    chk("rst_async_req", 32'(imem_req), 32'h0);
    chk("rst_async_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    op_q.delete();
    pc_q.delete();
    imem_ack = 1'b1; imem_rdata = mkw(6'h05);
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = '0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (sos !== 1'b0 || imem_req !== 1'b0) bad++;
    end
    chk("stale_ack_instr", instr, 32'h0);
    chk("stale_ack_opcode", 32'(opcode), 32'h0);
    chk("stale_ack_quiet", 32'(bad), 32'h0);
    run = 1'b1;
    fetch(mkw(6'h0D), 0); exec(2, 0, 0, 0, 0, 0, 1);                       // pc 4

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
